gpmc_host: RTL

//  GPMC bus initiator: plays the ARM-processor side of the multiplexed address/data GPMC link.
//  A simple request/response port is turned into csn/advn/wen/oen/ad cycles that the FPGA-side

---
 rtl/gpmc_host.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/gpmc_host.sv
// ============================================================================
// Module  : gpmc_host
// Purpose : GPMC bus initiator that turns a request/response port into
//           multiplexed address/data csn/advn/wein/oen cycles.
//           Optional macro GPMC_HOST_CLKOUT_EN enables gpmc_clk = clk/2 while
//           csn1 is low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpmc_host #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 5,
   parameter int ADDR_CYCLES = 2,
   parameter int TURN_CYCLES = 1,
   parameter int DATA_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   inout  wire  [DATA_WIDTH-1:0] gpmc_ad,
   output logic                  gpmc_advn,
   output logic                  gpmc_csn1,
   output logic                  gpmc_wein,
   output logic                  gpmc_oen,
   output logic                  gpmc_clk
);

   localparam int C_MAX_AT = (ADDR_CYCLES > TURN_CYCLES) ? ADDR_CYCLES : TURN_CYCLES;
   localparam int C_MAX    = (C_MAX_AT > DATA_CYCLES) ? C_MAX_AT : DATA_CYCLES;
   localparam int CNT_W    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ADDR    = 3'd1;
   localparam logic [2:0] S_TURN    = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_RECOVER = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  csn_q, csn_d, advn_q, advn_d, wen_q, wen_d, oen_q, oen_d;
   logic                  rspv_q, rspv_d, adoe_q, adoe_d;
   logic [DATA_WIDTH-1:0] adout_q, adout_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_ADDR;
               cnt_d   = CNT_W'(ADDR_CYCLES - 1);
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end
         S_ADDR: begin
            if (cnt_q == '0) begin
               if (we_q) begin
                  state_d = S_DATA;
                  cnt_d   = CNT_W'(DATA_CYCLES - 1);
               end else begin
                  state_d = S_TURN;
                  cnt_d   = CNT_W'(TURN_CYCLES - 1);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_TURN: begin
            if (cnt_q == '0) begin
               state_d = S_DATA;
               cnt_d   = CNT_W'(DATA_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               state_d = S_RECOVER;
               if (!we_q) rdata_d = gpmc_ad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RECOVER: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so every pin leaves a flop
   always_comb begin
      csn_d   = 1'b1;
      advn_d  = 1'b1;
      wen_d   = 1'b1;
      oen_d   = 1'b1;
      rspv_d  = 1'b0;
      adoe_d  = 1'b0;
      adout_d = '0;
      case (state_d)
         S_ADDR: begin
            csn_d   = 1'b0;
            advn_d  = 1'b0;
            adoe_d  = 1'b1;
            adout_d = DATA_WIDTH'(addr_d);
         end
         S_TURN: begin
            csn_d = 1'b0;
            oen_d = 1'b0;
         end
         S_DATA: begin
            csn_d = 1'b0;
            if (we_d) begin
               wen_d   = 1'b0;
               adoe_d  = 1'b1;
               adout_d = wdata_d;
            end else begin
               oen_d = 1'b0;
            end
         end
         S_RECOVER: rspv_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csn_q   <= 1'b1;
         advn_q  <= 1'b1;
         wen_q   <= 1'b1;
         oen_q   <= 1'b1;
         rspv_q  <= 1'b0;
         adoe_q  <= 1'b0;
         adout_q <= '0;
      end else begin
         csn_q   <= csn_d;
         advn_q  <= advn_d;
         wen_q   <= wen_d;
         oen_q   <= oen_d;
         rspv_q  <= rspv_d;
         adoe_q  <= adoe_d;
         adout_q <= adout_d;
      end
   end

`ifdef GPMC_HOST_CLKOUT_EN
   logic gclk_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gclk_q <= 1'b0;
      else        gclk_q <= csn_d ? 1'b0 : ~gclk_q;
   end
   assign gpmc_clk = gclk_q;
`else
   assign gpmc_clk = 1'b0;
`endif

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = rspv_q;
   assign rsp_rdata = rdata_q;
   assign gpmc_ad   = adoe_q ? adout_q : {DATA_WIDTH{1'bz}};
   assign gpmc_csn1 = csn_q;
   assign gpmc_advn = advn_q;
   assign gpmc_wein = wen_q;
   assign gpmc_oen  = oen_q;

endmodule

`default_nettype wire
